// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs 4 little-endian bytes per word and holds the CPU until loaded.
// Optional trailing checksum byte check is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] DONE    = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK   = 3'd3;
`endif

  logic [2:0]        state;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       lo_bytes;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  // Saturate the requested count to the address space and return the final word index.
  function automatic logic [ADDR_W-1:0] sat_last_idx(input logic [ADDR_W:0] n);
    if (n[ADDR_W])
      return '1;
    else
      return n[ADDR_W-1:0] - ADDR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_idx  <= '0;
      last_idx  <= '0;
      byte_cnt  <= '0;
      lo_bytes  <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum       <= '0;
      error     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            last_idx <= sat_last_idx(num_words);
            word_idx <= '0;
            byte_cnt <= '0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= '0;
            error    <= 1'b0;
`endif
            if (num_words == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CHECK;
              in_ready <= 1'b1;
`else
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state    <= COLLECT;
              in_ready <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (in_valid && in_ready) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum + in_byte;
`endif
            case (byte_cnt)
              2'd0: lo_bytes[7:0]   <= in_byte;
              2'd1: lo_bytes[15:8]  <= in_byte;
              2'd2: lo_bytes[23:16] <= in_byte;
              default: begin
                state     <= WRITE;
                in_ready  <= 1'b0;
                mem_we    <= 1'b1;
                mem_addr  <= word_idx;
                mem_wdata <= {in_byte, lo_bytes};
              end
            endcase
          end
        end

        WRITE: begin
          mem_we <= 1'b0;
          if (word_idx == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= CHECK;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            word_idx <= word_idx + ADDR_W'(1);
            byte_cnt <= '0;
            state    <= COLLECT;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (in_valid && in_ready) begin
            error    <= (in_byte != sum);
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            in_ready <= 1'b0;
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

`ifndef IMEM_LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif

endmodule
